// File: rtl/sort_mem_pkg.sv
// Shared types for the sorter memory responder.
// Holds the FSM state encoding, operation kind and default widths.
package sort_mem_pkg;

    localparam int SORT_AW = 8;
    localparam int SORT_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/sort_mem_array.sv
// Word array for the sorter memory responder.
// Single combined write port; handshake write takes priority over backdoor.
module sort_mem_array
    import sort_mem_pkg::*;
#(
    parameter int AW = SORT_AW,
    parameter int DW = SORT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    logic          port_en;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_data;

    always_comb begin
        port_en   = we | ld_en;
        port_addr = we ? waddr : ld_addr;
        port_data = we ? wdata : ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (port_en) begin
            mem_q[port_addr] <= port_data;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sort_mem_responder.sv
// Memory-side responder for the sorter readMem/writeMem/rdyMem handshake.
// One access at a time, fixed latency, one-cycle rdy pulse, backdoor preload.
module sort_mem_responder
    import sort_mem_pkg::*;
#(
    parameter int AW      = SORT_AW,
    parameter int DW      = SORT_DW,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read_mem,
    input  logic          write_mem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          rdy,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    op_t           op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic          commit;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    sort_mem_array #(
        .AW(AW),
        .DW(DW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (mem_we),
        .waddr  (addr_q),
        .wdata  (wdata_q),
        .ld_en  (ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .raddr  (addr_q),
        .rdata  (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_mem ^ write_mem) begin
                    op_d    = write_mem ? OP_WR : OP_RD;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end else if (read_mem && write_mem) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = RELEASE;
                    if (op_q == OP_RD) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                // Held requests must drop before another can be accepted.
                if (!read_mem && !write_mem) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = commit && (op_q == OP_WR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign rdy   = rdy_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);

endmodule
